// File: rtl/op_dispatch_if.sv
// Request/dispatch bundle shared by the requesters, the op scheduler and the input synchronizer.
// The slave modport is the scheduler's view; master is the environment driving it.
interface op_dispatch_if #(
  parameter int N_REQ      = 4,
  parameter int FIFO_DEPTH = 8
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [N_REQ-1:0]    req_valid;
  logic [16*N_REQ-1:0] req_op;
  logic [N_REQ-1:0]    req_ready;
  logic [15:0]         idx_op;
  logic                op_valid;
  logic                op_ack;
  logic [15:0]         target_busy;
  logic [CW-1:0]       fifo_count;
  logic                drop_err;
  logic                timeout_err;

  modport master (
    output req_valid, req_op, op_ack, target_busy,
    input  req_ready, idx_op, op_valid, fifo_count, drop_err, timeout_err
  );

  modport slave (
    input  req_valid, req_op, op_ack, target_busy,
    output req_ready, idx_op, op_valid, fifo_count, drop_err, timeout_err
  );
endinterface

// File: rtl/op_dispatch_scheduler.sv
// Round-robin arbitration of N_REQ op sources into a FIFO, drained one op at a time onto
// the single idx_op path with per-target busy, exclusive-task locking and ack timeout.
module op_dispatch_scheduler #(
  parameter int N_REQ       = 4,
  parameter int FIFO_DEPTH  = 8,
  parameter int ACK_TIMEOUT = 64
) (
  input  logic         clk,
  input  logic         rst_n,
  op_dispatch_if.slave bus
);
  localparam int RW = $clog2(N_REQ);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int TW = $clog2(ACK_TIMEOUT);
  localparam logic [AW:0]   PTR_ONE   = 1;
  localparam logic [TW-1:0] TMR_ONE   = 1;
  localparam logic [TW-1:0] TMR_LAST  = TW'(ACK_TIMEOUT - 1);
  localparam logic [AW:0]   DEPTH_VAL = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic {IDLE, ISSUE} state_e;

  state_e          state_q, state_d;
  logic [RW-1:0]   rrPtr_q;
  logic [AW:0]     wrPtr_q, rdPtr_q;
  logic [15:0]     mem_q [FIFO_DEPTH];
  logic [15:0]     idxOp_q, idxOp_d;
  logic            opValid_q, opValid_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic            exclLock_q, exclLock_d;
  logic [3:0]      lockTid_q, lockTid_d;
  logic            timeoutErr_q, timeoutErr_d;
  logic            dropErr_q;

  logic [AW:0]     count;
  logic            fifoFull, fifoEmpty;
  logic [N_REQ-1:0] hiMask, hiReq;
  logic            grantAny;
  logic [RW-1:0]   grantIdx;
  logic [15:0]     grantOp;
  logic            opLegal, push, pop;
  logic [15:0]     head;
  logic [3:0]      headTid;

  function automatic logic isExcl(input logic [3:0] tid);
    return (tid >= 4'd4) && (tid <= 4'd6);
  endfunction

  assign count     = wrPtr_q - rdPtr_q;
  assign fifoFull  = (count == DEPTH_VAL);
  assign fifoEmpty = (count == '0);
  assign head      = mem_q[rdPtr_q[AW-1:0]];
  assign headTid   = head[11:8];

  // Prefer the lowest requester at or above the pointer, else wrap to the lowest overall.
  always_comb begin
    grantAny = 1'b0;
    grantIdx = '0;
    grantOp  = '0;
    hiMask   = '0;
    for (int i = 0; i < N_REQ; i++) hiMask[i] = (i >= int'(rrPtr_q));
    hiReq = bus.req_valid & hiMask;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (bus.req_valid[i]) begin
        grantAny = 1'b1;
        grantIdx = RW'(i);
      end
    end
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (hiReq[i]) grantIdx = RW'(i);
    end
    if (fifoFull || !rst_n) grantAny = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grantIdx == RW'(i)) grantOp = bus.req_op[16*i +: 16];
    end
  end

  assign opLegal = ((grantOp[11:8] >= 4'd1)  && (grantOp[11:8] <= 4'd6))  ||
                   ((grantOp[11:8] >= 4'd10) && (grantOp[11:8] <= 4'd12)) ||
                   ((grantOp[11:8] == 4'd0)  && (grantOp[7:4] == 4'hF));
  assign push = grantAny && opLegal;

  always_comb begin
    state_d      = state_q;
    idxOp_d      = idxOp_q;
    opValid_d    = opValid_q;
    timer_d      = timer_q;
    exclLock_d   = exclLock_q;
    lockTid_d    = lockTid_q;
    timeoutErr_d = 1'b0;
    pop          = 1'b0;
    if (exclLock_q && !bus.target_busy[lockTid_q]) exclLock_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifoEmpty && !bus.target_busy[headTid] && !(exclLock_q && isExcl(headTid))) begin
          pop       = 1'b1;
          idxOp_d   = head;
          opValid_d = 1'b1;
          timer_d   = '0;
          state_d   = ISSUE;
        end
      end
      ISSUE: begin
        if (bus.op_ack) begin
          idxOp_d   = '0;
          opValid_d = 1'b0;
          state_d   = IDLE;
          if (isExcl(idxOp_q[11:8])) begin
            exclLock_d = 1'b1;
            lockTid_d  = idxOp_q[11:8];
          end
        end else if (timer_q == TMR_LAST) begin
          idxOp_d      = '0;
          opValid_d    = 1'b0;
          timeoutErr_d = 1'b1;
          state_d      = IDLE;
        end else begin
          timer_d = timer_q + TMR_ONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      idxOp_q      <= '0;
      opValid_q    <= 1'b0;
      timer_q      <= '0;
      exclLock_q   <= 1'b0;
      lockTid_q    <= '0;
      timeoutErr_q <= 1'b0;
      dropErr_q    <= 1'b0;
      rrPtr_q      <= '0;
      wrPtr_q      <= '0;
      rdPtr_q      <= '0;
    end else begin
      state_q      <= state_d;
      idxOp_q      <= idxOp_d;
      opValid_q    <= opValid_d;
      timer_q      <= timer_d;
      exclLock_q   <= exclLock_d;
      lockTid_q    <= lockTid_d;
      timeoutErr_q <= timeoutErr_d;
      dropErr_q    <= grantAny && !opLegal;
      if (grantAny) rrPtr_q <= (grantIdx == RW'(N_REQ - 1)) ? '0 : grantIdx + RW'(1);
      if (push) wrPtr_q <= wrPtr_q + PTR_ONE;
      if (pop) rdPtr_q <= rdPtr_q + PTR_ONE;
    end
  end

  // Storage needs no reset: entries are only read between the reset-cleared pointers.
  always_ff @(posedge clk) begin
    if (push) mem_q[wrPtr_q[AW-1:0]] <= grantOp;
  end

  assign bus.req_ready   = grantAny ? (N_REQ'(1) << grantIdx) : '0;
  assign bus.idx_op      = idxOp_q;
  assign bus.op_valid    = opValid_q;
  assign bus.fifo_count  = count;
  assign bus.drop_err    = dropErr_q;
  assign bus.timeout_err = timeoutErr_q;
endmodule
